// File: rtl/rs_syndrome_calculator.sv
// RS(204,188) syndrome engine: Horner-evaluates S1..S16 = r(alpha^0..alpha^15) over GF(2^8)/0x11D, one byte per cycle.
// Latency: results and a one-cycle Syndrome_Valid appear after the edge sampling the last byte; no backpressure, gaps via Data_Valid.
module rs_syndrome_calculator #(
   parameter int PKT_LEN = 204
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] Data_In,
   input  logic       Data_Valid,
   input  logic       Sop,
   output logic [7:0] S1,
   output logic [7:0] S2,
   output logic [7:0] S3,
   output logic [7:0] S4,
   output logic [7:0] S5,
   output logic [7:0] S6,
   output logic [7:0] S7,
   output logic [7:0] S8,
   output logic [7:0] S9,
   output logic [7:0] S10,
   output logic [7:0] S11,
   output logic [7:0] S12,
   output logic [7:0] S13,
   output logic [7:0] S14,
   output logic [7:0] S15,
   output logic [7:0] S16,
   output logic       Syndrome_Valid,
   output logic       Error_Flag
);

   localparam int CNT_W = $clog2(PKT_LEN + 1);

   typedef enum logic {IDLE, ACCUM} state_t;

   // Multiply by alpha, then by alpha^k with constant k: collapses to a pure XOR network.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
   endfunction

   function automatic logic [7:0] mul_apow(input logic [7:0] a, input int k);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < k; i++) begin
         r = xtime(r);
      end
      return r;
   endfunction

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [15:0][7:0]       acc_q, acc_d;
   logic [15:0][7:0]       syn_q, syn_d;
   logic [15:0][7:0]       horner;
   logic                   sv_q, sv_d;
   logic                   ef_q, ef_d;

   always_comb begin
      for (int j = 0; j < 16; j++) begin
         horner[j] = mul_apow(acc_q[j], j) ^ Data_In;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      syn_d   = syn_q;
      sv_d    = 1'b0;
      ef_d    = ef_q;
      if (Data_Valid) begin
         if (Sop) begin
            // Sop always restarts, discarding any partial packet.
            acc_d   = {16{Data_In}};
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
         end else if (state_q == ACCUM) begin
            acc_d = horner;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(PKT_LEN - 1)) begin
               syn_d   = horner;
               ef_d    = |horner;
               sv_d    = 1'b1;
               state_d = IDLE;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         syn_q   <= '0;
         sv_q    <= 1'b0;
         ef_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         syn_q   <= syn_d;
         sv_q    <= sv_d;
         ef_q    <= ef_d;
      end
   end

   assign S1  = syn_q[0];
   assign S2  = syn_q[1];
   assign S3  = syn_q[2];
   assign S4  = syn_q[3];
   assign S5  = syn_q[4];
   assign S6  = syn_q[5];
   assign S7  = syn_q[6];
   assign S8  = syn_q[7];
   assign S9  = syn_q[8];
   assign S10 = syn_q[9];
   assign S11 = syn_q[10];
   assign S12 = syn_q[11];
   assign S13 = syn_q[12];
   assign S14 = syn_q[13];
   assign S15 = syn_q[14];
   assign S16 = syn_q[15];
   assign Syndrome_Valid = sv_q;
   assign Error_Flag     = ef_q;

endmodule

// File: tb/tb_rs_syndrome_calculator.sv
// Bench for rs_syndrome_calculator: directed and random packets, gaps, aborts and reset, checked against
// hand constants or a direct polynomial-evaluation model; inputs change on negedge, outputs sampled on negedge.
module tb_rs_syndrome_calculator;
   localparam int PKT = 204;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic [7:0] Data_In = 8'h00;
   logic       Data_Valid = 1'b0;
   logic       Sop = 1'b0;
   logic [7:0] S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13, S14, S15, S16;
   logic       Syndrome_Valid, Error_Flag;

   always #5 Clk = ~Clk;

   rs_syndrome_calculator #(.PKT_LEN(PKT)) dut (
      .Clk(Clk), .Reset(Reset), .Data_In(Data_In), .Data_Valid(Data_Valid), .Sop(Sop),
      .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6), .S7(S7), .S8(S8),
      .S9(S9), .S10(S10), .S11(S11), .S12(S12), .S13(S13), .S14(S14), .S15(S15), .S16(S16),
      .Syndrome_Valid(Syndrome_Valid), .Error_Flag(Error_Flag)
   );

   wire [127:0] s_all = {S16, S15, S14, S13, S12, S11, S10, S9, S8, S7, S6, S5, S4, S3, S2, S1};

   typedef struct packed {
      logic [127:0] s;
      logic         ef;
      logic [31:0]  cyc;
   } res_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc = 0;
   res_t        pq[$];
   res_t        eq[$];
   res_t        mon_r, exp_r, got_r, want_r;
   logic [7:0]  pkt [PKT];

   localparam logic [127:0] ONES   = {16{8'h01}};
   localparam logic [127:0] R1_TAB = {8'h26, 8'h13, 8'h87, 8'hCD, 8'hE8, 8'h74, 8'h3A, 8'h1D,
                                      8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (Syndrome_Valid === 1'b1) begin
         mon_r.s   = s_all;
         mon_r.ef  = Error_Flag;
         mon_r.cyc = cyc;
         pq.push_back(mon_r);
      end
   end

   // Carry-less product then reduction by 0x11D.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
      return p[7:0];
   endfunction

   // Sj = sum_i r_i * alpha^((j-1)*i), with r_i = pkt[PKT-1-i].
   function automatic logic [127:0] model();
      logic [127:0] res;
      logic [7:0]   x, pw, acc;
      res = '0;
      for (int j = 0; j < 16; j++) begin
         x = 8'h01;
         for (int k = 0; k < j; k++) x = gf_mul(x, 8'h02);
         pw  = 8'h01;
         acc = 8'h00;
         for (int i = 0; i < PKT; i++) begin
            acc = acc ^ gf_mul(pkt[PKT-1-i], pw);
            pw  = gf_mul(pw, x);
         end
         res[8*j +: 8] = acc;
      end
      return res;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] d, input logic s);
      @(negedge Clk);
      Data_Valid = 1'b1;
      Sop        = s;
      Data_In    = d;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge Clk);
         Data_Valid = 1'b0;
         Sop        = 1'($urandom);
         Data_In    = 8'($urandom);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clk);
         Data_Valid = 1'b0;
         Sop        = 1'b0;
      end
   endtask

   task automatic fill_zero();
      for (int i = 0; i < PKT; i++) pkt[i] = 8'h00;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < PKT; i++) pkt[i] = 8'($urandom);
   endtask

   // gapmode: 0 none, 1 random gaps, 2 random gaps plus 10 idle cycles before the last byte.
   task automatic send(input logic [127:0] exp, input int nbytes, input int gapmode);
      for (int i = 0; i < nbytes; i++) begin
         if (gapmode != 0 && i > 0 && $urandom_range(3) == 0) gap($urandom_range(4, 1));
         if (gapmode == 2 && i == PKT - 1) gap(10);
         drive(pkt[i], i == 0);
      end
      if (nbytes == PKT) begin
         exp_r.s   = exp;
         exp_r.ef  = |exp;
         exp_r.cyc = cyc + 1;
         eq.push_back(exp_r);
      end
   endtask

   task automatic check_pulses(input string tag);
      idle(3);
      chk({tag, "_npulse"}, 128'(pq.size()), 128'(eq.size()));
      chk({tag, "_sv_low"}, 128'(Syndrome_Valid), 128'(0));
      while (pq.size() > 0 && eq.size() > 0) begin
         got_r  = pq.pop_front();
         want_r = eq.pop_front();
         chk({tag, "_syn"}, got_r.s, want_r.s);
         chk({tag, "_ef"}, 128'(got_r.ef), 128'(want_r.ef));
         chk({tag, "_cyc"}, 128'(got_r.cyc), 128'(want_r.cyc));
         if (pq.size() == 0) chk({tag, "_hold"}, s_all, want_r.s);
      end
      pq.delete();
      eq.delete();
   endtask

   initial begin
      // Reset state, including a Sop presented while reset is held.
      idle(2);
      drive(8'hA5, 1'b1);
      idle(1);
      chk("rst_syn", s_all, 128'h0);
      chk("rst_sv", 128'(Syndrome_Valid), 128'(0));
      chk("rst_ef", 128'(Error_Flag), 128'(0));
      @(negedge Clk) Reset = 1'b1;
      idle(2);

      fill_zero();
      send(128'h0, PKT, 0);
      check_pulses("zero");

      fill_zero(); pkt[PKT-1] = 8'h01;
      send(ONES, PKT, 0);
      check_pulses("r0");

      fill_zero(); pkt[PKT-2] = 8'h01;
      send(R1_TAB, PKT, 0);
      check_pulses("r1");

      send(R1_TAB, PKT, 2);
      check_pulses("r1_gaps");

      // Valid bytes without Sop in IDLE must be ignored.
      for (int i = 0; i < 5; i++) drive(8'($urandom), 1'b0);
      for (int p = 0; p < 3; p++) begin
         fill_rand();
         send(model(), PKT, 0);
      end
      check_pulses("rand_b2b");

      for (int p = 0; p < 3; p++) begin
         fill_rand();
         send(model(), PKT, 1);
         gap($urandom_range(3));
      end
      check_pulses("rand_gaps");

      fill_rand();
      send(128'h0, 100, 0);
      fill_zero();
      send(128'h0, PKT, 0);
      check_pulses("abort100");

      fill_rand();
      send(128'h0, PKT - 1, 1);
      fill_zero(); pkt[PKT-1] = 8'h01;
      send(ONES, PKT, 0);
      check_pulses("abort_last");

      fill_rand();
      send(model(), PKT, 0);
      check_pulses("pre_rst");
      fill_rand();
      send(128'h0, 150, 1);
      @(negedge Clk) Reset = 1'b0;
      #1;
      chk("midrst_syn", s_all, 128'h0);
      chk("midrst_ef", 128'(Error_Flag), 128'(0));
      idle(2);
      chk("midrst_sv", 128'(Syndrome_Valid), 128'(0));
      chk("midrst_np", 128'(pq.size()), 128'(0));
      @(negedge Clk) Reset = 1'b1;
      idle(2);
      fill_zero(); pkt[PKT-1] = 8'h01;
      send(ONES, PKT, 0);
      fill_zero();
      send(128'h0, PKT, 0);
      idle(3);
      if (pq.size() == 2) chk("post_rst_spacing", 128'(pq[1].cyc - pq[0].cyc), 128'(PKT));
      check_pulses("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
